// File: rtl/recognizer_seq_ctrl_pkg.sv
// Shared definitions for the recognizer sequencer.
//   - state_e : FSM encoding (IDLE, SHIFT, DRAIN, DONE)
//   - WIDTH_DEF / CW_DEF : default word width and match-count width
package recognizer_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int CW_DEF    = 5;

endpackage

// File: rtl/recognizer_seq_ctrl_piso_shift.sv
// Parallel-in / serial-out shift register with an MSB tap.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (clears the register)
//   load_i  : capture data_i (has priority over shift_i)
//   shift_i : shift left by one, zero fill
//   data_i  : parallel word
//   msb_o   : current MSB (next bit to present serially)
module recognizer_seq_ctrl_piso_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/recognizer_seq_ctrl.sv
// Sequencer for a serial sequence recognizer. A word captured on start is
// shifted MSB-first onto x_out, one bit per clock; z_in is sampled and the
// hits are recorded per data bit (match_map) and counted (match_count).
// The recognizer is held in reset (rec_reset) whenever no run is active.
//
// Handshake: start is only looked at in IDLE; an accepted start captures
// data on that edge. busy is high from the following cycle until done, which
// pulses for exactly one cycle. There is no queuing: start while busy is
// dropped. Results hold until the next accepted start.
//
// Ports:
//   clk, reset (async, active low)
//   start, data         : run request and word to shift
//   z_in / x_out        : recognizer output / input
//   rec_reset           : active-high reset to the recognizer
//   busy, done          : run status, one-cycle completion pulse
//   match_count, match_map : results of the last run
//   state_dbg           : current FSM state (debug visibility)
module recognizer_seq_ctrl
    import recognizer_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CW      = CW_DEF,
    parameter int Z_DELAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             z_in,
    output logic             x_out,
    output logic             rec_reset,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    match_count,
    output logic [WIDTH-1:0] match_map,
    output logic [1:0]       state_dbg
);

    // One counter spans SHIFT and DRAIN: it is the index of the z sample
    // taken on each edge of the run.
    localparam int IW = $clog2(WIDTH + Z_DELAY + 1);
    localparam logic [IW-1:0] LAST_SHIFT = IW'(WIDTH - 1);
    localparam logic [IW-1:0] LAST_RUN   = IW'(WIDTH + Z_DELAY - 1);
    localparam logic [IW-1:0] MAP_TOP    = IW'(WIDTH - 1 + Z_DELAY);
    localparam logic [CW-1:0] CNT_MAX    = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] map_q, map_d;

    logic             accept;
    logic             sampling;
    logic             credit_ok;
    logic             shift_msb;
    logic [IW-1:0]    map_pos;
    logic [WIDTH-1:0] credit_mask;

    assign accept   = (state_q == ST_IDLE) && start;
    assign sampling = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);

    // Sample s credits data bit WIDTH-1-(s-Z_DELAY); the first Z_DELAY
    // samples belong to no data bit and are dropped.
    assign map_pos     = MAP_TOP - bitcnt_q;
    assign credit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << map_pos;

    if (Z_DELAY == 0) begin : g_no_discard
        assign credit_ok = 1'b1;
    end else begin : g_discard
        localparam logic [IW-1:0] ZD = IW'(Z_DELAY);
        assign credit_ok = (bitcnt_q >= ZD);
    end

    recognizer_seq_ctrl_piso_shift #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (accept),
        .shift_i (state_q == ST_SHIFT),
        .data_i  (data),
        .msb_o   (shift_msb)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (bitcnt_q == LAST_SHIFT)
                          state_d = (Z_DELAY > 0) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (bitcnt_q == LAST_RUN) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        x_out     = (state_q == ST_SHIFT) && shift_msb;
        rec_reset = (state_q == ST_IDLE) || (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    // Run counter and result accumulation
    always_comb begin
        bitcnt_d = bitcnt_q;
        count_d  = count_q;
        map_d    = map_q;
        if (accept) begin
            bitcnt_d = '0;
            count_d  = '0;
            map_d    = '0;
        end else if (sampling) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (credit_ok && z_in) begin
                map_d = map_q | credit_mask;
                if (count_q < CNT_MAX) count_d = count_q + 1'b1;
            end
        end else if (state_q == ST_DONE) begin
            bitcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt_q <= '0;
            count_q  <= '0;
            map_q    <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            count_q  <= count_d;
            map_q    <= map_d;
        end
    end

    assign match_count = count_q;
    assign match_map   = map_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_recognizer_seq_ctrl.sv
// Bench for recognizer_seq_ctrl. Two instances: a Mealy "101" recognizer
// stub (Z_DELAY=0) and a registered-z stub (Z_DELAY=1). Expected results are
// pushed when a run is started and popped when done is seen.
module tb_recognizer_seq_ctrl;

    localparam int W  = 16;
    localparam int CW = 5;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0 (Mealy stub) ----------------
    logic          start0 = 1'b0;
    logic [W-1:0]  data0  = '0;
    logic          z0, x0, rr0, busy0, done0;
    logic [CW-1:0] cnt0;
    logic [W-1:0]  map0;
    logic [1:0]    st0;
    logic [1:0]    h0 = 2'b00;

    recognizer_seq_ctrl #(.WIDTH(W), .CW(CW), .Z_DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .data(data0), .z_in(z0),
        .x_out(x0), .rec_reset(rr0), .busy(busy0), .done(done0),
        .match_count(cnt0), .match_map(map0), .state_dbg(st0)
    );

    assign z0 = (h0 == 2'b10) && x0;
    always @(posedge clk) begin
        if (rr0) h0 <= 2'b00;
        else     h0 <= {h0[0], x0};
    end

    // ---------------- DUT 1 (registered-z stub) ----------------
    logic          start1 = 1'b0;
    logic [W-1:0]  data1  = '0;
    logic          z1, x1, rr1, busy1, done1;
    logic [CW-1:0] cnt1;
    logic [W-1:0]  map1;
    logic [1:0]    st1;
    logic [1:0]    h1 = 2'b00;
    logic          z1_q = 1'b0;

    recognizer_seq_ctrl #(.WIDTH(W), .CW(CW), .Z_DELAY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .data(data1), .z_in(z1),
        .x_out(x1), .rec_reset(rr1), .busy(busy1), .done(done1),
        .match_count(cnt1), .match_map(map1), .state_dbg(st1)
    );

    assign z1 = z1_q;
    always @(posedge clk) begin
        if (rr1) begin
            h1   <= 2'b00;
            z1_q <= 1'b0;
        end else begin
            z1_q <= (h1 == 2'b10) && x1;
            h1   <= {h1[0], x1};
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: "101" overlapping detector over the word MSB-first.
    function automatic logic [CW+W-1:0] model(input logic [W-1:0] d);
        logic [1:0]    h = 2'b00;
        logic [CW-1:0] c = '0;
        logic [W-1:0]  m = '0;
        logic          x;
        for (int k = 0; k < W; k++) begin
            x = d[W-1-k];
            if (h == 2'b10 && x) begin
                c++;
                m[W-1-k] = 1'b1;
            end
            h = {h[0], x};
        end
        return {c, m};
    endfunction

    // ---------------- scoreboard ----------------
    logic [CW+W-1:0] exp0_q[$];
    logic [CW+W-1:0] exp1_q[$];
    logic [CW+W-1:0] e0, e1;

    always @(negedge clk) begin
        if (done0) begin
            check("done_expected0", exp0_q.size() != 0, 1);
            if (exp0_q.size() != 0) begin
                e0 = exp0_q.pop_front();
                check("count0", cnt0, e0[CW+W-1:W]);
                check("map0", map0, e0[W-1:0]);
            end
        end
        if (done1) begin
            check("done_expected1", exp1_q.size() != 0, 1);
            if (exp1_q.size() != 0) begin
                e1 = exp1_q.pop_front();
                check("count1", cnt1, e1[CW+W-1:W]);
                check("map1", map1, e1[W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge right after the start-accept edge.
    task automatic start_run(input int sel, input logic [W-1:0] d);
        @(negedge clk);
        if (sel == 0) begin data0 = d; start0 = 1'b1; end
        else          begin data1 = d; start1 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget, output int at);
        int seen;
        seen = 0;
        at   = -1;
        for (int i = 0; i < budget && seen == 0; i++) begin
            if ((sel == 0) ? done0 : done1) begin
                seen = 1;
                at   = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("done_seen", seen, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            c0, t1, t2;
        logic [W-1:0]  d;

        // Reset values
        #1;
        check("rst_x", x0, 0);
        check("rst_rec_reset", rr0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_count", cnt0, 0);
        check("rst_map", map0, 0);
        check("rst_state", st0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 0x0005: serial order, latency, single match on bit 0
        d = 16'h0005;
        exp0_q.push_back({5'd1, 16'h0001});
        start_run(0, d);
        check("shift_rec_reset", rr0, 0);
        for (int i = 0; i < W; i++) begin
            check("x_seq", x0, d[W-1-i]);
            @(negedge clk);
        end
        check("done_latency", done0, 1);
        @(negedge clk);
        check("busy_after_done", busy0, 0);
        check("done_one_cycle", done0, 0);
        check("idle_rec_reset", rr0, 1);

        // 0xAAAA: no credit before bit 13, data change mid-run ignored
        exp0_q.push_back({5'd7, 16'h2AAA});
        start_run(0, 16'hAAAA);
        data0 = 16'($urandom_range(0, 16'hFFFF));
        @(negedge clk);
        check("early_count_k0", cnt0, 0);
        @(negedge clk);
        check("early_count_k1", cnt0, 0);
        @(negedge clk);
        check("first_credit_count", cnt0, 1);
        check("first_credit_map", map0, 16'h2000);
        wait_done(0, 40, t1);
        @(negedge clk);

        // Reset in IDLE clears held results without a clock edge
        #2 reset = 1'b0;
        #1;
        check("idle_reset_count", cnt0, 0);
        check("idle_reset_map", map0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Abort mid-SHIFT at bit 5 of 0xFFFF
        start_run(0, 16'hFFFF);
        repeat (5) @(negedge clk);
        check("abort_pre_x", x0, 1);
        check("abort_pre_busy", busy0, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_x", x0, 0);
        check("abort_rec_reset", rr0, 1);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_count", cnt0, 0);
        check("abort_map", map0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle_state", st0, 0);
        check("abort_idle_busy", busy0, 0);

        // start re-pulsed during a run is ignored
        exp0_q.push_back({5'd0, 16'h0000});
        start_run(0, 16'h0000);
        c0 = cyc;
        repeat (4) @(negedge clk);
        data0  = 16'hFFFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 40, t1);
        check("repulse_latency", t1 - c0, 16);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check("hold_count", cnt0, 0);
            check("hold_map", map0, 0);
            check("hold_busy", busy0, 0);
            @(negedge clk);
        end

        // start held high: back-to-back runs
        exp0_q.push_back({5'd1, 16'h0001});
        exp0_q.push_back({5'd7, 16'h2AAA});
        data0  = 16'h0005;
        start0 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        wait_done(0, 40, t1);
        check("b2b_first_latency", t1 - c0, 16);
        data0 = 16'hAAAA;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        data0  = 16'h0000;
        @(negedge clk);
        wait_done(0, 40, t2);
        check("b2b_spacing", t2 - t1, 18);
        @(negedge clk);

        // Z_DELAY=1: one DRAIN cycle, done after edge 17
        exp1_q.push_back({5'd7, 16'h2AAA});
        start_run(1, 16'hAAAA);
        c0 = cyc;
        repeat (W) @(negedge clk);
        check("drain_state", st1, 2);
        check("drain_x", x1, 0);
        check("drain_rec_reset", rr1, 0);
        check("drain_no_done", done1, 0);
        wait_done(1, 40, t1);
        check("drain_latency", t1 - c0, 17);
        @(negedge clk);

        // Random words on both instances
        for (int r = 0; r < 6; r++) begin
            int sel;
            sel = r % 2;
            d = 16'($urandom_range(0, 16'hFFFF));
            if (sel == 0) exp0_q.push_back(model(d));
            else          exp1_q.push_back(model(d));
            start_run(sel, d);
            c0 = cyc;
            wait_done(sel, 40, t1);
            check("rand_latency", t1 - c0, 16 + sel);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("queue_empty0", exp0_q.size(), 0);
        check("queue_empty1", exp1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/recognizer_seq_ctrl.md
Name: recognizer_seq_ctrl

Overview:
- Sequencer that drives a serial sequence recognizer.
- Accepts a WIDTH-bit word on a start strobe and holds the recognizer in reset between runs.
- Shifts the word MSB-first into the recognizer's x input, one bit per clock, and samples the recognizer's z output.
- Reports per-bit match positions and a match count; sits between a bus-side requester and one recognizer instance.

Parameters:
WIDTH, 16, bits per word shifted per run
CW, 5, match_count width (must hold WIDTH; log2(WIDTH)+1)
Z_DELAY, 0, clocks from a bit appearing on x_out to its z response (0 = Mealy recognizer, 1 = Moore)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  run request, sampled only in IDLE
data  in  WIDTH  word to shift; captured on the accepted start
z_in  in  1  recognizer z output
x_out  out  1  recognizer x input
rec_reset  out  1  active-high reset to recognizer
busy  out  1  high in SHIFT, DRAIN, DONE
done  out  1  one-cycle completion pulse
match_count  out  CW  number of z=1 samples credited this run
match_map  out  WIDTH  bit j set if z=1 was credited to data bit j

Behaviour:
- reset low (async): state=IDLE, x_out=0, rec_reset=1, busy=0, done=0, match_count=0, match_map=0, bit/drain counters=0.
- States are IDLE, SHIFT, DRAIN and DONE.
- IDLE:
  - rec_reset=1, x_out=0.
  - On start=1 at an edge: shreg<=data, match_count<=0, match_map<=0, bitcnt<=0, go to SHIFT.
- SHIFT:
  - rec_reset=0; x_out=shreg[WIDTH-1] (combinational from shreg, so the first bit is valid the cycle after start is accepted).
  - Each edge: shreg shifts left by 1, bitcnt increments.
  - After WIDTH edges: go to DRAIN if Z_DELAY>0, else DONE.
- DRAIN:
  - x_out=0, rec_reset=0, runs for Z_DELAY edges, then go to DONE.
- z sampling:
  - z_in is sampled on every edge in SHIFT and DRAIN.
  - The first Z_DELAY samples are discarded.
  - The k-th credited sample (k=0..WIDTH-1) maps to data bit WIDTH-1-k.
  - On z=1: set that match_map bit; match_count+=1 (saturates at WIDTH, unreachable by construction).
- DONE: done=1 for exactly one cycle, rec_reset=1, then go to IDLE.
- Latency: done is high in the cycle after edge WIDTH+Z_DELAY, counted from the start-accept edge (edge 0).
- match_count and match_map hold their values through IDLE until the next accepted start.
- start while busy: ignored, no queuing.
- start held high continuously: a new run begins on the first IDLE edge after DONE, i.e. back-to-back runs with one IDLE cycle between them.
- data changing during a run has no effect (captured copy only).
- reset asserted mid-run: immediate abort to reset values; partial results are lost.
- rec_reset=1 in IDLE/DONE, so recognizer state never carries across runs; overlapping matches within a run are counted.

Decomposition:
- Shared header/package holds:
  - state encodings: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DRAIN=2'd2, ST_DONE=2'd3
  - default WIDTH/CW constants
- One natural sub-module, piso_shift (load/shift register with MSB tap), instantiated for shreg.
- Counters and FSM live in the top module.
- The recognizer is not instantiated inside; the bench connects it.

Test Plan:
Bench recognizer stub: Mealy (Z_DELAY=0), z=1 when the last three x bits are 101, overlapping. Edge 0 = start-accept edge.
1. reset low mid-SHIFT at bit 5 of data=16'hFFFF -> x_out=0, rec_reset=1, busy=0, count=0, map=0 immediately, without waiting for a clock edge; after release, IDLE.
2. data=16'h0005, start pulse -> x_out sequence 0x13,1,0,1; done high in the cycle after edge 16; match_count=1, match_map=16'h0001; busy low after done.
3. data=16'hAAAA -> match_count=7, match_map=16'h2AAA; no matches credited before bit 13.
4. start re-pulsed during SHIFT of data=16'h0000 -> ignored; single done pulse; count=0, map=0; results stable in IDLE for 20 cycles.
5. start held high, data=16'h0005 then 16'hAAAA -> two runs, done pulses 18 cycles apart; second run count=7, proving no carry-over from run 1.
6. Z_DELAY=1 with a registered-z stub, data=16'hAAAA -> one DRAIN cycle, done after edge 17, map=16'h2AAA.
